afe_buf_ctrl: RTL

AFE_BUF_CTRL -- requirements
Module: afe_buf_ctrl

---
 rtl/afe_buf_pkg.sv | 14 +
 rtl/afe_buf_if.sv | 16 +
 rtl/afe_buf_ptr.sv | 26 ++
 rtl/afe_buf_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/afe_buf_pkg.sv
// Shared definitions for the AFE sample buffer controller: the per-cycle
// SRAM access type and the default widths.
package afe_buf_pkg;

  localparam int DEF_ADC_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH     = 10;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } acc_t;

endpackage

// File: rtl/afe_buf_if.sv
// Single-port SRAM bus between the buffer controller (master) and the
// SRAM macro (slave). Enables are active-low; read data arrives one cycle
// after the read access.
interface afe_buf_if #(
  parameter int DW = afe_buf_pkg::DEF_ADC_DATA_WIDTH,
  parameter int AW = afe_buf_pkg::DEF_ADDR_WIDTH
);
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output cen, output wen, output addr, output wdata, input rdata);
  modport slave  (input cen, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/afe_buf_ptr.sv
// Wrapping circular-buffer pointer: counts 0..2^W-1 and back to 0, with a
// synchronous clear that overrides the increment.
module afe_buf_ptr #(
  parameter int W = afe_buf_pkg::DEF_ADDR_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Natural W-bit overflow gives the DEPTH-1 -> 0 wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/afe_buf_ctrl.sv
// Controller that runs a single-port SRAM as a circular FIFO for ADC samples:
// unstallable writes win over reads, with fill tracking, overflow and threshold events.
module afe_buf_ctrl
  import afe_buf_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = DEF_ADC_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic [ADDR_WIDTH:0]       cfg_thresh_i,
  input  logic                      adc_valid_i,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data_i,
  input  logic                      rd_req_i,
  output logic                      rd_gnt_o,
  output logic                      rd_valid_o,
  output logic [ADC_DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]       fill_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      ovf_o,
  output logic                      thresh_evt_o,
  output logic                      sram_cen_o,
  output logic                      sram_wen_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr_o,
  output logic [ADC_DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [ADC_DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_FULL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] FILL_ONE  = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_ovf;
  logic                  r_rd_valid;
  logic                  r_thresh_evt;

  logic [ADDR_WIDTH-1:0] w_wptr;
  logic [ADDR_WIDTH-1:0] w_rptr;
  logic [ADDR_WIDTH:0]   w_fill_inc;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_go;
  logic                  w_wr_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_drop;
  acc_t                  w_acc;

  assign w_full     = (r_fill == FILL_FULL);
  assign w_empty    = (r_fill == '0);
  assign w_fill_inc = r_fill + FILL_ONE;

  // Reset and clear both suppress every access and grant in their cycle.
  assign w_go     = rstn_i & ~cfg_clr_i;
  assign w_wr_req = w_go & cfg_en_i & adc_valid_i;
  assign w_wr     = w_wr_req & ~w_full;
  assign w_drop   = w_wr_req & w_full;
  assign w_rd     = w_go & rd_req_i & ~w_empty & ~w_wr;

  always_comb begin
    w_acc = ACC_IDLE;
    if (w_wr) begin
      w_acc = ACC_WRITE;
    end else if (w_rd) begin
      w_acc = ACC_READ;
    end
  end

  afe_buf_ptr #(.W(ADDR_WIDTH)) u_wptr (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_clr  (cfg_clr_i),
    .i_inc  (w_wr),
    .o_ptr  (w_wptr)
  );

  afe_buf_ptr #(.W(ADDR_WIDTH)) u_rptr (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_clr  (cfg_clr_i),
    .i_inc  (w_rd),
    .o_ptr  (w_rptr)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i || cfg_clr_i) begin
      r_fill       <= '0;
      r_ovf        <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_thresh_evt <= 1'b0;
    end else begin
      r_rd_valid   <= w_rd;
      r_thresh_evt <= w_wr && (cfg_thresh_i != '0) && (w_fill_inc == cfg_thresh_i);
      if (w_wr) begin
        r_fill <= w_fill_inc;
      end else if (w_rd) begin
        r_fill <= r_fill - FILL_ONE;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // A read in flight is squashed combinationally if reset or clear lands on its data cycle.
  assign rd_gnt_o     = (w_acc == ACC_READ);
  assign rd_valid_o   = r_rd_valid & w_go;
  assign rd_data_o    = rd_valid_o ? sram_rdata_i : '0;
  assign fill_o       = r_fill;
  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign ovf_o        = r_ovf;
  assign thresh_evt_o = r_thresh_evt;

  assign sram_cen_o   = (w_acc == ACC_IDLE);
  assign sram_wen_o   = (w_acc != ACC_WRITE);
  assign sram_addr_o  = (w_acc == ACC_WRITE) ? w_wptr : w_rptr;
  assign sram_wdata_o = (w_acc == ACC_WRITE) ? adc_data_i : '0;

endmodule
